// File: rtl/mem_xfer_pkg.sv
// Shared types and helpers for the cache-line transfer engine (mem_line_xfer).
package mem_xfer_pkg;

    localparam int XFER_LINE_WORDS = 4;
    localparam int XFER_OFF_W      = $clog2(XFER_LINE_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } xfer_state_e;

    // Clears the low off_w bits so the result is the word address of the line start.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int off_w);
        return addr & ~((64'd1 << off_w) - 64'd1);
    endfunction

endpackage

// File: rtl/mem_line_xfer_if.sv
// Bundle of the cache-side request/response and memory-side signals of mem_line_xfer.
interface mem_line_xfer_if #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    // req and resp are valid/ready channels: a transfer happens on the posedge where
    // valid and ready are both high; the sender holds its payload stable until then.
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_wb;
    logic [ADDR_W-1:0]            req_wb_addr;
    logic [LINE_WORDS*DATA_W-1:0] req_wb_line;
    logic [ADDR_W-1:0]            req_fill_addr;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [LINE_WORDS*DATA_W-1:0] resp_line;
    logic                         crit_valid;
    logic [DATA_W-1:0]            crit_word;
    logic                         mem_ren;
    logic                         mem_wen;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_din;
    logic [DATA_W-1:0]            mem_dout;

    modport slave (
        input  req_valid, req_wb, req_wb_addr, req_wb_line, req_fill_addr, resp_ready, mem_dout,
        output req_ready, resp_valid, resp_line, crit_valid, crit_word,
               mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_wb, req_wb_addr, req_wb_line, req_fill_addr, resp_ready, mem_dout,
        input  req_ready, resp_valid, resp_line, crit_valid, crit_word,
               mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_xfer_line_buf.sv
// One cache line of registers: whole-line load, single-word indexed write, flat read.
module mem_xfer_line_buf #(
    parameter int LINE_WORDS = 4,
    parameter int DATA_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_en,
    input  logic [LINE_WORDS*DATA_W-1:0] ld_line,
    input  logic                         wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_idx,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [LINE_WORDS*DATA_W-1:0] line
);
    logic [DATA_W-1:0] words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
        end else if (ld_en) begin
            for (int i = 0; i < LINE_WORDS; i++) words[i] <= ld_line[i*DATA_W +: DATA_W];
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_WORDS; i++) line[i*DATA_W +: DATA_W] = words[i];
    end
endmodule

// File: rtl/mem_line_xfer.sv
// Cache-line transfer engine: optional line writeback, then line refill, one word per cycle.
// Define CRIT_WORD_FIRST_EN to read the critical word first and pulse crit_valid.
module mem_line_xfer
    import mem_xfer_pkg::*;
#(
    parameter int LINE_WORDS = XFER_LINE_WORDS,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_line_xfer_if.slave bus,
    output logic [2:0]     dbg_state
);
    localparam int              OFF_W   = $clog2(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST   = OFF_W'(LINE_WORDS - 1);
    localparam logic [2:0]      S_IDLE  = 3'(IDLE);
    localparam logic [2:0]      S_WB    = 3'(WB);
    localparam logic [2:0]      S_RD    = 3'(RD);
    localparam logic [2:0]      S_DRAIN = 3'(DRAIN);
    localparam logic [2:0]      S_RESP  = 3'(RESP);

    logic [2:0]                   state;
    logic [OFF_W-1:0]             cnt;
    logic [OFF_W-1:0]             rd_idx;
    logic [OFF_W-1:0]             cap_idx;
    logic                         cap_en;
    logic                         accept;
    logic [ADDR_W-1:0]            wb_base;
    logic [ADDR_W-1:0]            fill_base;
    logic [LINE_WORDS*DATA_W-1:0] wb_line;
    logic [LINE_WORDS*DATA_W-1:0] fill_line;
`ifdef CRIT_WORD_FIRST_EN
    logic [OFF_W-1:0]             offset;
`endif

    assign accept    = (state == S_IDLE) && bus.req_valid;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wb_base   <= '0;
            fill_base <= '0;
`ifdef CRIT_WORD_FIRST_EN
            offset    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    wb_base   <= ADDR_W'(line_base(64'(bus.req_wb_addr), OFF_W));
                    fill_base <= ADDR_W'(line_base(64'(bus.req_fill_addr), OFF_W));
`ifdef CRIT_WORD_FIRST_EN
                    offset    <= bus.req_fill_addr[OFF_W-1:0];
`endif
                    cnt       <= '0;
                    state     <= bus.req_wb ? S_WB : S_RD;
                end
                S_WB: begin
                    cnt <= cnt + OFF_W'(1);
                    if (cnt == LAST) state <= S_RD;
                end
                S_RD: begin
                    cnt <= cnt + OFF_W'(1);
                    if (cnt == LAST) state <= S_DRAIN;
                end
                S_DRAIN: state <= S_RESP;
                S_RESP:  if (bus.resp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Counter wraps modulo LINE_WORDS, so base|idx never carries into the tag bits.
`ifdef CRIT_WORD_FIRST_EN
    assign rd_idx = offset + cnt;
`else
    assign rd_idx = cnt;
`endif

    // Read data lags its strobe by one cycle; DRAIN (cnt back at 0) collects the last word.
    assign cap_idx = rd_idx - OFF_W'(1);
    assign cap_en  = ((state == S_RD) && (cnt != '0)) || (state == S_DRAIN);

    mem_xfer_line_buf #(.LINE_WORDS(LINE_WORDS), .DATA_W(DATA_W)) u_wb_buf (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (accept),
        .ld_line (bus.req_wb_line),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .line    (wb_line)
    );

    mem_xfer_line_buf #(.LINE_WORDS(LINE_WORDS), .DATA_W(DATA_W)) u_fill_buf (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (1'b0),
        .ld_line ('0),
        .wr_en   (cap_en),
        .wr_idx  (cap_idx),
        .wr_data (bus.mem_dout),
        .line    (fill_line)
    );

    always_comb begin
        bus.req_ready  = (state == S_IDLE);
        bus.resp_valid = (state == S_RESP);
        bus.resp_line  = (state == S_RESP) ? fill_line : '0;
        bus.mem_wen    = (state == S_WB);
        bus.mem_ren    = (state == S_RD);
        bus.mem_addr   = '0;
        bus.mem_din    = '0;
        if (state == S_WB) begin
            bus.mem_addr = wb_base | ADDR_W'(cnt);
            bus.mem_din  = wb_line[cnt*DATA_W +: DATA_W];
        end else if (state == S_RD) begin
            bus.mem_addr = fill_base | ADDR_W'(rd_idx);
        end
`ifdef CRIT_WORD_FIRST_EN
        bus.crit_valid = (state == S_RD) && (cnt == OFF_W'(1));
        bus.crit_word  = bus.crit_valid ? bus.mem_dout : '0;
`else
        bus.crit_valid = 1'b0;
        bus.crit_word  = '0;
`endif
    end
endmodule

// File: tb/tb_mem_line_xfer.sv
// Bench for mem_line_xfer: behavioural word memory plus a line-level reference model.
`timescale 1ns/1ps
module tb_mem_line_xfer;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LINE_W = LW * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  mem_line_xfer_if #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_line_xfer #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- memory (mem_behav) ----------------
  logic [31:0] mem_arr [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hA5A5_0000;
  endfunction
  always @(posedge clk) begin
    if (bus.mem_wen) mem_arr[bus.mem_addr] = bus.mem_din;
    if (bus.mem_ren) bus.mem_dout <= mem_rd(bus.mem_addr);
  end

  // ---------------- reference model memory ----------------
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [73:0] pack(input int c, input logic w, input logic r,
                                       input logic [31:0] a, input logic [31:0] d);
    return {8'(c), w, r, a, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble();
    bus.req_wb        = 1'($urandom_range(0, 1));
    bus.req_wb_addr   = $urandom;
    bus.req_fill_addr = $urandom;
    bus.req_wb_line   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Entered just after a posedge; returns just after the handshake posedge.
  task automatic run_req(input logic wb, input logic [31:0] wb_addr, input logic [LINE_W-1:0] wb_line,
                         input logic [31:0] fill_addr, input int hold, input bit keep);
    logic [73:0] exp_q[$];
    logic [73:0] obs_q[$];
    logic [31:0] bw, bf, crit_w, exp_crit_w;
    logic [LINE_W-1:0] exp_line;
    int off, c, resp_n, exp_resp_n, crit_n, crit_cnt, exp_crit_n;
    bit done;

    bw = wb_addr & ~(32'(LW) - 32'd1);
    bf = fill_addr & ~(32'(LW) - 32'd1);
`ifdef CRIT_WORD_FIRST_EN
    off = int'(fill_addr % 32'(LW));
`else
    off = 0;
`endif
    c = 1;
    if (wb) begin
      for (int k = 0; k < LW; k++) begin
        exp_q.push_back(pack(c, 1'b1, 1'b0, bw + 32'(k), wb_line[k*DW +: DW]));
        ref_mem[bw + 32'(k)] = wb_line[k*DW +: DW];
        c++;
      end
    end
    for (int k = 0; k < LW; k++) begin
      exp_q.push_back(pack(c, 1'b0, 1'b1, bf + 32'((off + k) % LW), 32'd0));
      c++;
    end
    exp_resp_n = c + 1;
    for (int i = 0; i < LW; i++) exp_line[i*DW +: DW] = ref_rd(bf + 32'(i));
    exp_crit_n = (wb ? LW : 0) + 2;
    exp_crit_w = ref_rd(bf + 32'(off));

    bus.req_valid     = 1'b1;
    bus.req_wb        = wb;
    bus.req_wb_addr   = wb_addr;
    bus.req_wb_line   = wb_line;
    bus.req_fill_addr = fill_addr;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    if (keep) scramble();
    else bus.req_valid = 1'b0;

    resp_n = 0; crit_n = 0; crit_cnt = 0; crit_w = '0; done = 0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      if (bus.mem_wen || bus.mem_ren) begin
        check("mem_excl", bus.mem_wen & bus.mem_ren, 1'b0);
        obs_q.push_back(pack(n, bus.mem_wen, bus.mem_ren, bus.mem_addr,
                             bus.mem_wen ? bus.mem_din : 32'd0));
      end
      if (bus.crit_valid) begin
        crit_cnt++;
        crit_n = n;
        crit_w = bus.crit_word;
      end
      if (bus.resp_valid) begin
        resp_n = n;
        done = 1;
      end else begin
        check("req_ready_busy", bus.req_ready, 1'b0);
        if (keep) scramble();
      end
    end

    check("resp_cycle", resp_n, exp_resp_n);
    check("access_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check("access", obs_q[i], exp_q[i]);
`ifdef CRIT_WORD_FIRST_EN
    check("crit_count", crit_cnt, 1);
    check("crit_cycle", crit_n, exp_crit_n);
    check("crit_word", crit_w, exp_crit_w);
`else
    check("crit_count", crit_cnt, 0);
    check("crit_word_tied", bus.crit_word, 32'd0);
`endif
    if (!done) begin
      @(posedge clk);
      #1;
      return;
    end
    check("resp_line", bus.resp_line, exp_line);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_resp_valid", bus.resp_valid, 1'b1);
      check("hold_resp_line", bus.resp_line, exp_line);
      check("hold_req_ready", bus.req_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt_resp;
    logic [LINE_W-1:0] line;

    bus.req_valid = 1'b0; bus.req_wb = 1'b0; bus.req_wb_addr = '0;
    bus.req_wb_line = '0; bus.req_fill_addr = '0; bus.resp_ready = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_line", bus.resp_line, '0);
    check("rst_mem_ren", bus.mem_ren, 1'b0);
    check("rst_mem_wen", bus.mem_wen, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_crit_valid", bus.crit_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // plain fill
    run_req(1'b0, 32'h0, '0, 32'h0000_0012, 0, 1'b0);
    // writeback then fill of the same line returns written data
    line = {32'd4, 32'd3, 32'd2, 32'd1};
    run_req(1'b1, 32'h20, line, 32'h20, 0, 1'b0);
    // critical word inside the line
    run_req(1'b0, 32'h0, '0, 32'h0000_0037, 0, 1'b0);
    // response backpressure
    run_req(1'b0, 32'h0, '0, 32'h0000_0045, 5, 1'b0);
    // line at the top of the address space must not carry
    line = {$urandom, $urandom, $urandom, $urandom};
    run_req(1'b1, 32'hFFFF_FFF9, line, 32'hFFFF_FFFE, 1, 1'b0);

    // reset in cycle 2 of a fill
    bus.req_valid = 1'b1; bus.req_wb = 1'b0; bus.req_fill_addr = 32'h50;
    @(negedge clk);
    check("rst5_req_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst5_ren_c1", bus.mem_ren, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst5_mem_ren", bus.mem_ren, 1'b0);
    check("rst5_req_ready", bus.req_ready, 1'b1);
    rst = 1'b0;
    cnt_resp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) cnt_resp++;
    end
    check("rst5_no_resp", cnt_resp, 0);
    @(posedge clk);
    #1;
    run_req(1'b0, 32'h0, '0, 32'h0000_0051, 0, 1'b0);

    // req_valid held high across back-to-back requests with changing payloads
    line = {$urandom, $urandom, $urandom, $urandom};
    run_req(1'b0, 32'h0, '0, 32'h0000_0062, 0, 1'b1);
    run_req(1'b1, 32'h0000_0068, line, 32'h0000_0069, 0, 1'b1);
    run_req(1'b0, 32'h0, '0, 32'h0000_006B, 2, 1'b1);
    run_req(1'b1, 32'h0000_0070, ~line, 32'h0000_0060, 0, 1'b0);

    // randomized requests over a small address window so lines collide
    for (int r = 0; r < 14; r++) begin
      line = {$urandom, $urandom, $urandom, $urandom};
      run_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)), line,
              32'($urandom_range(0, 127)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
